// File: rtl/fwrisc_csr_seq_if.sv
// Request/status bundle between decode and the CSR read-modify-write sequencer.
// master = decode side, slave = sequencer side.
interface fwrisc_csr_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [5:0]  req_idx;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic [4:0]  req_rd;
    logic        busy;
    logic        done;
    logic        illegal;

    modport master (
        output req_valid, req_op, req_idx, req_src, req_src_zero, req_rd,
        input  req_ready, busy, done, illegal
    );

    modport slave (
        input  req_valid, req_op, req_idx, req_src, req_src_zero, req_rd,
        output req_ready, busy, done, illegal
    );
endinterface

// File: rtl/fwrisc_csr_seq.sv
// Zicsr read-modify-write sequencer for the regfile's single read port B
// and single write port. Fixed 5-cycle op: read, capture, CSR write, rd write.
//
//   state | meaning
//   IDLE  | ready for a request
//   READ  | rf_raddr driven with the CSR index
//   CAPT  | old value arrives; new value and legality computed
//   WCSR  | CSR write (if intended and legal)
//   WRD   | old value to rd (if rd!=0 and legal), done pulse
module fwrisc_csr_seq #(
    parameter logic [2:0] CSR_RO_PREFIX = 3'b100
) (
    input  logic                  clock,
    input  logic                  reset,
    fwrisc_csr_seq_if.slave       req,
    output logic [5:0]            rf_raddr,
    input  logic [31:0]           rf_rdata,
    output logic [5:0]            rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic                  rf_wen
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_CAPT = 3'd2,
        S_WCSR = 3'd3,
        S_WRD  = 3'd4
    } state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_t      state, state_next;

    logic [1:0]  op_q;
    logic [5:0]  idx_q;
    logic [31:0] src_q;
    logic        src_zero_q;
    logic [4:0]  rd_q;
    logic [31:0] old_q;
    logic [31:0] new_q;
    logic        wr_csr_q;
    logic        illegal_q;
    logic [5:0]  hold_waddr;
    logic [31:0] hold_wdata;

    logic [31:0] new_c;
    logic        wr_csr_c;
    logic        illegal_c;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state: every step after acceptance is unconditional
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req.req_valid) state_next = S_READ;
            S_READ:  state_next = S_CAPT;
            S_CAPT:  state_next = S_WCSR;
            S_WCSR:  state_next = S_WRD;
            S_WRD:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Modify step and legality, evaluated against the value returned in CAPT
    always_comb begin
        new_c = src_q;
        case (op_q)
            OP_RW:   new_c = src_q;
            OP_RS:   new_c = rf_rdata | src_q;
            OP_RC:   new_c = rf_rdata & ~src_q;
            default: new_c = rf_rdata | src_q;
        endcase
        wr_csr_c  = (op_q == OP_RW) || !src_zero_q;
        illegal_c = wr_csr_c && ((idx_q[5:3] == CSR_RO_PREFIX) || (idx_q < 6'd32));
    end

    // Request latch, captured values, and held write address/data
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q       <= 2'b00;
            idx_q      <= 6'd0;
            src_q      <= 32'd0;
            src_zero_q <= 1'b0;
            rd_q       <= 5'd0;
            old_q      <= 32'd0;
            new_q      <= 32'd0;
            wr_csr_q   <= 1'b0;
            illegal_q  <= 1'b0;
            hold_waddr <= 6'd0;
            hold_wdata <= 32'd0;
        end else begin
            if (state == S_IDLE && req.req_valid) begin
                // Reserved op 00 behaves as a non-writing RS
                op_q       <= (req.req_op == 2'b00) ? OP_RS : req.req_op;
                src_zero_q <= req.req_src_zero || (req.req_op == 2'b00);
                idx_q      <= req.req_idx;
                src_q      <= req.req_src;
                rd_q       <= req.req_rd;
            end
            if (state == S_CAPT) begin
                old_q     <= rf_rdata;
                new_q     <= new_c;
                wr_csr_q  <= wr_csr_c;
                illegal_q <= illegal_c;
            end
            if (rf_wen) begin
                hold_waddr <= rf_waddr;
                hold_wdata <= rf_wdata;
            end
        end
    end

    // Outputs decoded from the registered state and latched values
    always_comb begin
        req.req_ready = (state == S_IDLE);
        req.busy      = (state != S_IDLE);
        req.done      = (state == S_WRD);
        req.illegal   = (state == S_WRD) && illegal_q;
        rf_raddr      = (state == S_READ) ? idx_q : 6'd0;
        rf_wen        = 1'b0;
        rf_waddr      = hold_waddr;
        rf_wdata      = hold_wdata;
        if (state == S_WCSR && wr_csr_q && !illegal_q) begin
            rf_wen   = 1'b1;
            rf_waddr = idx_q;
            rf_wdata = new_q;
        end else if (state == S_WRD && rd_q != 5'd0 && !illegal_q) begin
            rf_wen   = 1'b1;
            rf_waddr = {1'b0, rd_q};
            rf_wdata = old_q;
        end
    end

endmodule

// File: doc/fwrisc_csr_seq.md
Name: fwrisc_csr_seq

Overview:
- Sequences Zicsr read-modify-write instructions (CSRRW/CSRRS/CSRRC and immediate forms) onto the register file's single read port B and single write port.
- Sits between the decode/exec stage and fwrisc_regfile. Decode hands over a pre-mapped 6-bit CSR index, the operand value and the destination GPR.
- The block reads the old CSR value, writes the new CSR value and writes the old value to rd, using separate cycles because the write port is single.

Parameters:
- CSR_RO_PREFIX, 3'b100: value of idx[5:3] that marks a read-only CSR (indices 0x20-0x27).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  CSR op request
- req_ready  out  1  block idle; request accepted when req_valid && req_ready
- req_op  in  2  01=RW, 10=RS (set bits), 11=RC (clear bits); 00 reserved, treated as RS with src_zero=1
- req_idx  in  6  regfile CSR index (32-63)
- req_src  in  32  rs1 value or zero-extended zimm, already muxed by decode
- req_src_zero  in  1  rs1==x0 or zimm==0; suppresses the CSR write for RS/RC
- req_rd  in  5  destination GPR
- rf_raddr  out  6  to regfile rb_raddr
- rf_rdata  in  32  from regfile rb_rdata; valid one cycle after rf_raddr
- rf_waddr  out  6  to regfile rd_waddr
- rf_wdata  out  32  to regfile rd_wdata
- rf_wen  out  1  to regfile rd_wen
- busy  out  1  high while not IDLE; decode must not drive the regfile ports while high
- done  out  1  one-cycle pulse when the op completes
- illegal  out  1  qualifies done: op rejected, nothing written

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset: state=IDLE, req_ready=1, busy=0, done=0, illegal=0, rf_wen=0, rf_raddr=0, rf_waddr=0, rf_wdata=0. All latched request fields and old_q/new_q are cleared to 0.
- FSM states are IDLE, READ, CAPT, WCSR, WRD. Every transition is unconditional after acceptance, so latency is fixed.
- IDLE: req_ready=1. On accept, latch op/idx/src/src_zero/rd, then go to READ.
- READ: rf_raddr=idx_q; go to CAPT.
- CAPT:
  - old_q <= rf_rdata.
  - new_q <= src_q for RW; old|src for RS; old&~src for RC.
  - wr_csr = RW || !src_zero_q.
  - illegal_q = wr_csr && (idx_q[5:3]==CSR_RO_PREFIX || idx_q[5:0]<6'd32).
  - Go to WCSR.
- WCSR:
  - If wr_csr && !illegal_q: rf_wen=1, rf_waddr=idx_q, rf_wdata=new_q.
  - Otherwise rf_wen=0.
  - Go to WRD.
- WRD:
  - If rd_q!=0 && !illegal_q: rf_wen=1, rf_waddr={1'b0,rd_q}, rf_wdata=old_q.
  - done=1; illegal=illegal_q.
  - Go to IDLE.
- Latency: acceptance in cycle N gives CSR write in N+3, rd write and done in N+4, and req_ready=1 again in N+5. There are no back-to-back accepts.
- rf_raddr=0 and rf_wen=0 in every state other than those listed above. rf_waddr/rf_wdata hold their last value when rf_wen=0.
- Read-only CSR with no write intent (RS/RC with src_zero=1) is legal: no CSR write, rd still receives the value.
- rd==0: no rd write, done still pulses.
- CSRRW with rd==0 still performs the read, for fixed timing.
- Writes to the soft-reset CSR index are performed normally. The resulting soft-reset request is the regfile's concern.
- req_valid held while busy is ignored, not queued.
- Reset asserted in any state: next cycle IDLE, no rf_wen and no done, with the partial op discarded. A CSR write already performed in WCSR is not undone.
- All outputs are registered or decoded from the registered state. There is no combinational path from req_* to rf_* or done.

Test Plan:
- CSRRW idx=0x2A (mtvec, old 0x0), src=0x8000_0100, rd=5 -> N+3: wen, waddr=0x2A, wdata=0x8000_0100; N+4: wen, waddr=5, wdata=0x0, done=1, illegal=0.
- CSRRS idx=0x2A (value 0x0000_00F0), src=0x0F, rd=0 -> N+3 wdata=0x0000_00FF; N+4 no wen, done=1.
- CSRRC idx=0x2A (0x0000_00FF), src=0xF0 -> new value 0x0F; then CSRRS src_zero=1 rd=7 -> no CSR write, x7=0x0F.
- CSRRS src_zero=1 on read-only idx 0x21 (VENDORID param 0x1234), rd=3 -> no CSR write, x3=0x1234, illegal=0. Same with CSRRW -> no rf_wen in either cycle, done=1, illegal=1.
- req_valid held high for 10 cycles -> exactly two ops complete (accepts at N and N+5), req_ready low N+1..N+4.
- Reset pulsed in CAPT -> no rf_wen, no done, req_ready=1 next cycle; a new op afterwards completes normally.
